seq_stage_sequencer: RTL and testbench
======================================

// Module: seq_stage_sequencer
// PURPOSE
//  Multi-cycle controller for the SEQ Y86-64 datapath. Steps each instruction through
//  fetch, decode, execute, memory, writeback and PC-update, one stage-enable per cycle.
//  Handshakes with data memory, gates register-file writes by icode and owns processor Stat.
//  Sits above the fetch/decode/execute/memory/writeback blocks; decode reads regs on decode_en.
// PARAMETERS
//  MEM_TIMEOUT  16  max cycles in MEMORY awaiting dmem_ready before ADR fault (>=1)
//  CNT_W        32  width of cycle_count and instr_count
// PORTS
//  clk          in   1      clock, rising edge
//  rst_n        in   1      asynchronous active-low reset
//  run          in   1      1 = execute instructions; 0 = park in IDLE after current instr
//  icode        in   4      instruction code from fetch, sampled at end of FETCH
//  instr_valid  in   1      fetch decoded a legal ifun/format
//  imem_error   in   1      fetch address out of range
//  cnd          in   1      condition flag from execute (qualifies cmovXX writeback)
//  dmem_ready   in   1      data memory completed access this cycle
//  dmem_error   in   1      data memory address fault, valid with dmem_ready
//  fetch_en, decode_en, execute_en, memory_en, wb_en, pc_en  out 1  stage strobes (one-hot)
//  dmem_req     out  1      data memory request, held until dmem_ready
//  we_e         out  1      write valE to dstE (only during WRITEBACK)
//  we_m         out  1      write valM to dstM (only during WRITEBACK)
//  stat         out  3      1=AOK 2=HLT 3=ADR 4=INS
//  halted       out  1      sticky, 1 in HALT state
//  cycle_count  out  CNT_W  active cycles (not IDLE/HALT), saturating
//  instr_count  out  CNT_W  retired instructions, saturating
// BEHAVIOUR
//  States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPDATE, HALT.
//  Reset (async, rst_n=0): state IDLE, stat=1, halted=0, counters 0, icode_q=0, wait cnt 0;
//   all strobes, dmem_req, we_e, we_m = 0. Outputs are Moore decodes of state/icode_q.
//  IDLE: no strobes; run=1 -> FETCH next cycle.
//  FETCH: fetch_en=1; icode latched into icode_q. Priority on exit:
//   imem_error -> HALT stat=3; !instr_valid or icode>11 -> HALT stat=4;
//   icode==0 -> HALT stat=2; else DECODE.
//  DECODE -> EXECUTE unconditionally (1 cycle each).
//  EXECUTE -> MEMORY if icode_q in {4,5,8,9,10,11}, else WRITEBACK.
//  MEMORY: memory_en=dmem_req=1 every cycle in state. dmem_ready&dmem_error -> HALT stat=3;
//   dmem_ready&!dmem_error -> WRITEBACK; wait cnt reaching MEM_TIMEOUT cycles w/o ready ->
//   HALT stat=3. Wait cnt clears on MEMORY entry.
//  WRITEBACK: wb_en=1; we_e=1 for icode_q 3,6,8,9,10,11, and for 2 only if cnd=1;
//   we_m=1 for icode_q 5,11. Both may assert together (popq). -> PCUPDATE.
//  PCUPDATE: pc_en=1; instr_count+1; run=1 -> FETCH, run=0 -> IDLE.
//  HALT: sticky until rst_n; halted=1, no strobes, stat frozen, counters frozen.
//  Latency: non-memory instr 5 cycles F..P; memory instr 6 + (ready wait) cycles.
//  Boundaries: run dropped mid-instruction -> instruction completes, then IDLE; dmem_ready
//   outside MEMORY ignored; counters saturate at 2^CNT_W-1, no wrap; exactly one
//   strobe high in any non-IDLE/HALT state; reset mid-MEMORY drops dmem_req immediately.
// TESTING
//  1 rst_n low then run=1, icode=6 valid -> strobes F,D,E,W,P on cycles 1-5, we_e=1 in W,
//    instr_count=1, back in FETCH cycle 6.
//  2 icode=5 (mrmovq), dmem_ready after 3 wait cycles -> dmem_req high 3+1 cycles, we_m=1
//    we_e=0 in W, total 9 cycles, stat=1.
//  3 icode=2, cnd=0 -> we_e=0 in W; repeat with cnd=1 -> we_e=1; icode=11 -> we_e=we_m=1.
//  4 Faults: icode=0 -> stat=2 halted=1 after FETCH; icode=12 -> stat=4; imem_error -> stat=3;
//    no further strobes for 20 cycles.
//  5 MEMORY with dmem_ready held low, MEM_TIMEOUT=16 -> HALT stat=3 after 16 MEMORY cycles;
//    dmem_ready&dmem_error -> stat=3 immediately.
//  6 run deasserted during EXECUTE -> instr retires, IDLE after PCUPDATE; rst_n pulsed in
//    MEMORY -> all outputs 0, stat=1 asynchronously.

Source files
------------

// File: rtl/seq_stage_sequencer.sv
// Multi-cycle stage controller for the SEQ Y86-64 datapath: one stage strobe per cycle, owns Stat.
// Latency: 5 cycles FETCH..PCUPDATE for non-memory instructions, 6 + dmem wait for memory instructions.
// Backpressure: MEMORY holds dmem_req until dmem_ready; a missing response faults after MEM_TIMEOUT cycles.
module seq_stage_sequencer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [3:0]       icode,
    input  logic             instr_valid,
    input  logic             imem_error,
    input  logic             cnd,
    input  logic             dmem_ready,
    input  logic             dmem_error,
    output logic             fetch_en,
    output logic             decode_en,
    output logic             execute_en,
    output logic             memory_en,
    output logic             wb_en,
    output logic             pc_en,
    output logic             dmem_req,
    output logic             we_e,
    output logic             we_m,
    output logic [2:0]       stat,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FETCH     = 3'd1;
    localparam logic [2:0] S_DECODE    = 3'd2;
    localparam logic [2:0] S_EXECUTE   = 3'd3;
    localparam logic [2:0] S_MEMORY    = 3'd4;
    localparam logic [2:0] S_WRITEBACK = 3'd5;
    localparam logic [2:0] S_PCUPDATE  = 3'd6;
    localparam logic [2:0] S_HALT      = 3'd7;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    localparam int               WAIT_W   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [2:0]        state_q, state_d;
    logic [3:0]        icode_q, icode_d;
    logic [2:0]        stat_q, stat_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  cycle_q, cycle_d;
    logic [CNT_W-1:0]  instr_q, instr_d;
    logic              mem_op;
    logic              active;

    // rmmovq, mrmovq, call, ret, pushq, popq touch data memory
    assign mem_op = icode_q inside {4'd4, 4'd5, 4'd8, 4'd9, 4'd10, 4'd11};
    assign active = (state_q != S_IDLE) && (state_q != S_HALT);

    always_comb begin
        state_d = state_q;
        icode_d = icode_q;
        stat_d  = stat_q;
        wait_d  = wait_q;
        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                icode_d = icode;
                if (imem_error) begin
                    state_d = S_HALT;
                    stat_d  = STAT_ADR;
                end else if (!instr_valid || (icode > 4'd11)) begin
                    state_d = S_HALT;
                    stat_d  = STAT_INS;
                end else if (icode == 4'd0) begin
                    state_d = S_HALT;
                    stat_d  = STAT_HLT;
                end else begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: state_d = S_EXECUTE;
            S_EXECUTE: begin
                if (mem_op) begin
                    state_d = S_MEMORY;
                    wait_d  = '0;
                end else begin
                    state_d = S_WRITEBACK;
                end
            end
            S_MEMORY: begin
                if (dmem_ready) begin
                    if (dmem_error) begin
                        state_d = S_HALT;
                        stat_d  = STAT_ADR;
                    end else begin
                        state_d = S_WRITEBACK;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_HALT;
                    stat_d  = STAT_ADR;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_WRITEBACK: state_d = S_PCUPDATE;
            S_PCUPDATE:  state_d = run ? S_FETCH : S_IDLE;
            S_HALT:      state_d = S_HALT;
            default:     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cycle_d = cycle_q;
        instr_d = instr_q;
        if (active && (cycle_q != CNT_MAX)) cycle_d = cycle_q + 1'b1;
        if ((state_q == S_PCUPDATE) && (instr_q != CNT_MAX)) instr_d = instr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            icode_q <= 4'd0;
            stat_q  <= STAT_AOK;
            wait_q  <= '0;
            cycle_q <= '0;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            icode_q <= icode_d;
            stat_q  <= stat_d;
            wait_q  <= wait_d;
            cycle_q <= cycle_d;
            instr_q <= instr_d;
        end
    end

    assign fetch_en    = (state_q == S_FETCH);
    assign decode_en   = (state_q == S_DECODE);
    assign execute_en  = (state_q == S_EXECUTE);
    assign memory_en   = (state_q == S_MEMORY);
    assign wb_en       = (state_q == S_WRITEBACK);
    assign pc_en       = (state_q == S_PCUPDATE);
    assign dmem_req    = memory_en;
    // cmovXX (icode 2) only commits when the execute condition holds
    assign we_e        = wb_en && ((icode_q inside {4'd3, 4'd6, 4'd8, 4'd9, 4'd10, 4'd11}) ||
                                   ((icode_q == 4'd2) && cnd));
    assign we_m        = wb_en && ((icode_q == 4'd5) || (icode_q == 4'd11));
    assign stat        = stat_q;
    assign halted      = (state_q == S_HALT);
    assign cycle_count = cycle_q;
    assign instr_count = instr_q;

endmodule

// File: tb/tb_seq_stage_sequencer.sv
// Randomized bench for seq_stage_sequencer against a per-instruction stage-sequence model.
module tb_seq_stage_sequencer;

    localparam int CNT_W   = 5;
    localparam int TIMEOUT = 16;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             run;
    logic [3:0]       icode;
    logic             instr_valid;
    logic             imem_error;
    logic             cnd;
    logic             dmem_ready;
    logic             dmem_error;
    logic             fetch_en, decode_en, execute_en, memory_en, wb_en, pc_en;
    logic             dmem_req, we_e, we_m;
    logic [2:0]       stat;
    logic             halted;
    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] instr_count;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_cyc;
    int exp_instr;
    int exp_stat;

    seq_stage_sequencer #(.MEM_TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .icode(icode), .instr_valid(instr_valid),
        .imem_error(imem_error), .cnd(cnd), .dmem_ready(dmem_ready), .dmem_error(dmem_error),
        .fetch_en(fetch_en), .decode_en(decode_en), .execute_en(execute_en),
        .memory_en(memory_en), .wb_en(wb_en), .pc_en(pc_en), .dmem_req(dmem_req),
        .we_e(we_e), .we_m(we_m), .stat(stat), .halted(halted),
        .cycle_count(cycle_count), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic rnd_mem();
        dmem_ready = 1'($urandom_range(0, 1));
        dmem_error = 1'($urandom_range(0, 1));
    endtask

    function automatic int sat_inc(input int v);
        return (v < CNT_MAX) ? v + 1 : v;
    endfunction

    // Called at a negedge with inputs already driven; checks this cycle's outputs.
    task automatic cyc(input logic [5:0] strb, input logic req, input logic xe, input logic xm);
        #1;
        check("strobes", 32'({fetch_en, decode_en, execute_en, memory_en, wb_en, pc_en}), 32'(strb));
        check("dmem_req", 32'(dmem_req), 32'(req));
        check("we_e", 32'(we_e), 32'(xe));
        check("we_m", 32'(we_m), 32'(xm));
        check("stat_run", 32'(stat), 32'd1);
        check("halted_run", 32'(halted), 32'd0);
        if (strb != 6'b0) exp_cyc = sat_inc(exp_cyc);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        run   = 1'b0;
        #1;
        check("rst_strobes", 32'({fetch_en, decode_en, execute_en, memory_en, wb_en, pc_en}), 32'd0);
        check("rst_dmem_req", 32'(dmem_req), 32'd0);
        check("rst_we", 32'({we_e, we_m}), 32'd0);
        check("rst_stat", 32'(stat), 32'd1);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_cycles", 32'(cycle_count), 32'd0);
        check("rst_instrs", 32'(instr_count), 32'd0);
        exp_cyc   = 0;
        exp_instr = 0;
        exp_stat  = 1;
        @(negedge clk);
        rst_n = 1'b1;
        run   = 1'b1;
        cyc(6'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Walks one instruction from FETCH; model derived from the instruction-level rules.
    task automatic run_instr(input logic [3:0] ic, input bit vld, input bit ierr, input bit c,
                             input int d, input bit derr, input bit drop, input bit rstm,
                             output bit hlt, output bit ab);
        bit mem_op, xe, xm;
        hlt = 1'b0;
        ab  = 1'b0;
        icode = ic; instr_valid = vld; imem_error = ierr; cnd = c;
        rnd_mem();
        cyc(6'b100000, 1'b0, 1'b0, 1'b0);
        if (ierr)                 begin hlt = 1'b1; exp_stat = 3; return; end
        if (!vld || ic > 4'd11)   begin hlt = 1'b1; exp_stat = 4; return; end
        if (ic == 4'd0)           begin hlt = 1'b1; exp_stat = 2; return; end
        mem_op = ic inside {4'd4, 4'd5, 4'd8, 4'd9, 4'd10, 4'd11};
        xe = (ic inside {4'd3, 4'd6, 4'd8, 4'd9, 4'd10, 4'd11}) || (ic == 4'd2 && c);
        xm = (ic == 4'd5) || (ic == 4'd11);
        rnd_mem();
        cyc(6'b010000, 1'b0, 1'b0, 1'b0);
        rnd_mem();
        if (drop) run = 1'b0;
        cyc(6'b001000, 1'b0, 1'b0, 1'b0);
        if (mem_op) begin
            for (int m = 0; m < TIMEOUT; m++) begin
                if (rstm && m == 1) begin
                    check("mem_before_rst", 32'({memory_en, dmem_req}), 32'd3);
                    ab = 1'b1;
                    return;
                end
                dmem_ready = (m == d);
                dmem_error = (m == d) ? derr : 1'($urandom_range(0, 1));
                cyc(6'b000100, 1'b1, 1'b0, 1'b0);
                if (m == d) begin
                    if (derr) begin hlt = 1'b1; exp_stat = 3; return; end
                    break;
                end
                if (m == TIMEOUT - 1) begin hlt = 1'b1; exp_stat = 3; return; end
            end
        end
        rnd_mem();
        cyc(6'b000010, 1'b0, xe, xm);
        rnd_mem();
        cyc(6'b000001, 1'b0, 1'b0, 1'b0);
        exp_instr = sat_inc(exp_instr);
    endtask

    task automatic do_instr(input logic [3:0] ic, input bit vld, input bit ierr, input bit c,
                            input int d, input bit derr, input bit drop, input bit rstm);
        bit hlt, ab;
        run_instr(ic, vld, ierr, c, d, derr, drop, rstm, hlt, ab);
        if (ab) begin
            do_reset();
        end else if (hlt) begin
            check("halt_stat", 32'(stat), 32'(exp_stat));
            check("halt_flag", 32'(halted), 32'd1);
            check("halt_cycles", 32'(cycle_count), 32'(exp_cyc));
            check("halt_instrs", 32'(instr_count), 32'(exp_instr));
            for (int k = 0; k < 20; k++) begin
                run = 1'b1;
                icode = 4'($urandom_range(1, 11));
                instr_valid = 1'b1; imem_error = 1'b0;
                rnd_mem();
                #1;
                check("halt_quiet", 32'({fetch_en, decode_en, execute_en, memory_en, wb_en,
                                         pc_en, dmem_req, we_e, we_m}), 32'd0);
                @(negedge clk);
            end
            check("halt_stat_frozen", 32'(stat), 32'(exp_stat));
            check("halt_flag_sticky", 32'(halted), 32'd1);
            check("halt_cycles_frozen", 32'(cycle_count), 32'(exp_cyc));
            check("halt_instrs_frozen", 32'(instr_count), 32'(exp_instr));
            do_reset();
        end else begin
            check("cycle_count", 32'(cycle_count), 32'(exp_cyc));
            check("instr_count", 32'(instr_count), 32'(exp_instr));
            if (drop) begin
                for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
                    rnd_mem();
                    cyc(6'b0, 1'b0, 1'b0, 1'b0);
                end
                run = 1'b1;
                cyc(6'b0, 1'b0, 1'b0, 1'b0);
                check("idle_cycles_frozen", 32'(cycle_count), 32'(exp_cyc));
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b0; icode = 4'd0; instr_valid = 1'b0; imem_error = 1'b0;
        cnd = 1'b0; dmem_ready = 1'b0; dmem_error = 1'b0;
        exp_cyc = 0; exp_instr = 0; exp_stat = 1;
        @(negedge clk);
        do_reset();

        // directed: irmovq-like, mrmovq with wait, cmov both ways, popq, run drop
        do_instr(4'd6,  1, 0, 0, 0,  0, 0, 0);
        do_instr(4'd5,  1, 0, 0, 3,  0, 0, 0);
        do_instr(4'd2,  1, 0, 0, 0,  0, 0, 0);
        do_instr(4'd2,  1, 0, 1, 0,  0, 0, 0);
        do_instr(4'd11, 1, 0, 0, 1,  0, 0, 0);
        do_instr(4'd3,  1, 0, 0, 0,  0, 1, 0);
        do_instr(4'd8,  1, 0, 0, 0,  0, 1, 0);
        // directed faults
        do_instr(4'd0,  1, 0, 0, 0,  0, 0, 0);
        do_instr(4'd12, 1, 0, 0, 0,  0, 0, 0);
        do_instr(4'd6,  1, 1, 0, 0,  0, 0, 0);
        do_instr(4'd6,  0, 0, 0, 0,  0, 0, 0);
        do_instr(4'd5,  1, 0, 0, 30, 0, 0, 0);
        do_instr(4'd9,  1, 0, 0, 15, 0, 0, 0);
        do_instr(4'd4,  1, 0, 0, 0,  1, 0, 0);
        do_instr(4'd10, 1, 0, 0, 30, 0, 0, 1);
        // long run to saturate both counters
        for (int i = 0; i < 40; i++) do_instr(4'd1, 1, 0, 0, 0, 0, 0, 0);
        do_instr(4'd0, 1, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 250; i++) begin
            logic [3:0] ic;
            int d;
            ic = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 11));
            d  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 3));
            do_instr(ic, $urandom_range(0, 19) != 0, $urandom_range(0, 29) == 0,
                     1'($urandom_range(0, 1)), d, $urandom_range(0, 14) == 0,
                     $urandom_range(0, 5) == 0, $urandom_range(0, 39) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
